// File: rtl/sb_pkg.sv
// Shared defaults for the decode-stage register scoreboard.
package sb_pkg;
    localparam int SB_NREG = 32;
    localparam int SB_AW   = 5;
    localparam int SB_DW   = 32;
    localparam int SB_NFWD = 3;
    localparam int SB_CNTW = 2;
    localparam logic [SB_CNTW-1:0] CNT_MAX = '1;
endpackage

// File: rtl/sb_src_resolve.sv
// One source operand: youngest-first forward select and RAW hazard flag.
module sb_src_resolve
    import sb_pkg::*;
#(
    parameter int AW   = SB_AW,
    parameter int DW   = SB_DW,
    parameter int NFWD = SB_NFWD
) (
    input  logic [AW-1:0]      addr,
    input  logic               need,
    input  logic               pending,
    input  logic [DW-1:0]      rf_rdata,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD*DW-1:0] fwd_data,
    output logic [DW-1:0]      value,
    output logic               hazard
);
    logic found;

    always_comb begin
        value  = rf_rdata;
        hazard = 1'b0;
        found  = 1'b0;
        // With no pending write, any matching forward entry is stale.
        if (need && (addr != '0) && pending) begin
            hazard = 1'b1;
            for (int i = 0; i < NFWD; i++) begin
                if (!found && fwd_valid[i] && (fwd_dest[i*AW +: AW] == addr)) begin
                    found = 1'b1;
                    if (fwd_ready[i]) begin
                        value  = fwd_data[i*DW +: DW];
                        hazard = 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register pending counters,
// operand resolve for rs1/rs2, decode stall and stalled-cycle counter.
module id_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG = SB_NREG,
    parameter int AW   = SB_AW,
    parameter int DW   = SB_DW,
    parameter int NFWD = SB_NFWD,
    parameter int CNTW = SB_CNTW
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [AW-1:0]      rs1_addr,
    input  logic [AW-1:0]      rs2_addr,
    input  logic               rs1_need,
    input  logic               rs2_need,
    input  logic [DW-1:0]      rf_rdata1,
    input  logic [DW-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic               issue_fire,
    input  logic               issue_we,
    input  logic [AW-1:0]      issue_dest,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_dest,
    input  logic               flush,
    output logic [DW-1:0]      rs1_value,
    output logic [DW-1:0]      rs2_value,
    output logic               stall,
    output logic [31:0]        stall_cnt
);
    localparam logic [CNTW-1:0] CNT_FULL = {CNTW{1'b1}};

    logic [CNTW-1:0] cnt_q   [1:NREG-1];
    logic [CNTW-1:0] cnt_vec [NREG];
    logic [NREG-1:1] inc_hit;
    logic [NREG-1:1] dec_hit;
    logic            inc;
    logic            dec;
    logic            hazard1;
    logic            hazard2;
    logic            issue_full;

    // r0 is never tracked, so it always reads as idle.
    always_comb begin
        cnt_vec[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_vec[r] = cnt_q[r];
        end
    end

    sb_src_resolve #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_rs1 (
        .addr      (rs1_addr),
        .need      (rs1_need),
        .pending   (cnt_vec[rs1_addr] != '0),
        .rf_rdata  (rf_rdata1),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .value     (rs1_value),
        .hazard    (hazard1)
    );

    sb_src_resolve #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_rs2 (
        .addr      (rs2_addr),
        .need      (rs2_need),
        .pending   (cnt_vec[rs2_addr] != '0),
        .rf_rdata  (rf_rdata2),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .value     (rs2_value),
        .hazard    (hazard2)
    );

    assign issue_full = issue_we && (issue_dest != '0) && (cnt_vec[issue_dest] == CNT_FULL);
    assign stall      = hazard1 | hazard2 | issue_full;

    assign inc = issue_fire && issue_we && (issue_dest != '0);
    assign dec = wb_we && (wb_dest != '0) && (cnt_vec[wb_dest] != '0);

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_hit[r] = inc && (issue_dest == AW'(r));
            dec_hit[r] = dec && (wb_dest == AW'(r));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            // Simultaneous issue and retire on one register cancel out.
            for (int r = 1; r < NREG; r++) begin
                if (inc_hit[r] && !dec_hit[r]) begin
                    cnt_q[r] <= cnt_q[r] + CNTW'(1);
                end else if (dec_hit[r] && !inc_hit[r]) begin
                    cnt_q[r] <= cnt_q[r] - CNTW'(1);
                end
            end
        end
    end

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    issue_while_stalled: assert property (@(posedge clk) disable iff (!resetn)
        !(issue_fire && stall));
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with a per-register reference model.
module tb_id_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NFWD = 3;
    localparam int CMAX = 3;
    localparam logic [31:0] RF1 = 32'hA1A1_0000;
    localparam logic [31:0] RF2 = 32'hB2B2_0000;

    logic               clk = 1'b0;
    logic               resetn;
    logic [AW-1:0]      rs1_addr, rs2_addr;
    logic               rs1_need, rs2_need;
    logic [DW-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]    fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0] fwd_dest;
    logic [NFWD*DW-1:0] fwd_data;
    logic               issue_fire, issue_we, wb_we, flush;
    logic [AW-1:0]      issue_dest, wb_dest;
    logic [DW-1:0]      rs1_value, rs2_value;
    logic               stall;
    logic [31:0]        stall_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mcnt [NREG];
    logic [31:0] msc;

    always #5 clk = ~clk;

    id_scoreboard dut (
        .clk(clk), .resetn(resetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_need(rs1_need), .rs2_need(rs2_need),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .issue_fire(issue_fire), .issue_we(issue_we), .issue_dest(issue_dest),
        .wb_we(wb_we), .wb_dest(wb_dest), .flush(flush),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference resolve: a pending register must be found in the youngest
    // matching forward slot, and that slot must be ready.
    function automatic void mres(input logic [AW-1:0] a, input logic need,
                                 input logic [31:0] rf, output logic [31:0] v,
                                 output bit hz);
        int i;
        v  = rf;
        hz = 1'b0;
        if (!need || a == 0 || mcnt[a] == 0) return;
        i = 0;
        while (i < NFWD && !(fwd_valid[i] && fwd_dest[i*AW +: AW] == a)) i++;
        if (i == NFWD) hz = 1'b1;
        else if (fwd_ready[i]) v = fwd_data[i*DW +: DW];
        else hz = 1'b1;
    endfunction

    function automatic bit mstall();
        logic [31:0] v;
        bit h1, h2;
        mres(rs1_addr, rs1_need, rf_rdata1, v, h1);
        mres(rs2_addr, rs2_need, rf_rdata2, v, h2);
        return h1 || h2 || (issue_we && issue_dest != 0 && mcnt[issue_dest] == CMAX);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) mcnt[r] = 0;
            msc = 0;
        end else begin
            if (mstall() && msc != 32'hFFFF_FFFF) msc = msc + 1;
            if (flush) begin
                for (int r = 0; r < NREG; r++) mcnt[r] = 0;
            end else begin
                int id, wd;
                id = (issue_fire && issue_we && issue_dest != 0) ? int'(issue_dest) : -1;
                wd = (wb_we && wb_dest != 0 && mcnt[wb_dest] != 0) ? int'(wb_dest) : -1;
                if (id != wd) begin
                    if (id >= 0) mcnt[id] = mcnt[id] + 1;
                    if (wd >= 0) mcnt[wd] = mcnt[wd] - 1;
                end
            end
        end
    end

    // Continuous comparison against the model, mid-cycle.
    initial begin
        logic [31:0] v1, v2;
        bit h1, h2;
        forever begin
            @(negedge clk);
            #2;
            mres(rs1_addr, rs1_need, rf_rdata1, v1, h1);
            mres(rs2_addr, rs2_need, rf_rdata2, v2, h2);
            chk("model_stall", {31'd0, stall}, {31'd0, mstall()});
            chk("model_stall_cnt", stall_cnt, msc);
            if (!h1) chk("model_rs1_value", rs1_value, v1);
            if (!h2) chk("model_rs2_value", rs2_value, v2);
        end
    end

    task automatic clr();
        rs1_addr = '0; rs2_addr = '0; rs1_need = 1'b0; rs2_need = 1'b0;
        rf_rdata1 = RF1; rf_rdata2 = RF2;
        fwd_valid = '0; fwd_ready = '0; fwd_dest = '0; fwd_data = '0;
        issue_fire = 1'b0; issue_we = 1'b0; issue_dest = '0;
        wb_we = 1'b0; wb_dest = '0; flush = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
        clr();
    endtask

    task automatic fwd(input int i, input logic v, input logic r,
                       input logic [AW-1:0] d, input logic [31:0] x);
        fwd_valid[i] = v;
        fwd_ready[i] = r;
        fwd_dest[i*AW +: AW] = d;
        fwd_data[i*DW +: DW] = x;
    endtask

    task automatic issue(input logic [AW-1:0] d);
        issue_fire = 1'b1; issue_we = 1'b1; issue_dest = d;
    endtask

    task automatic wb(input logic [AW-1:0] d);
        wb_we = 1'b1; wb_dest = d;
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        rs1_addr = a; rs1_need = 1'b1;
    endtask

    initial begin
        int guard;
        resetn = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        rd1(5'd5);
        #2;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_rs1_rf", rs1_value, RF1);
        nxt();
        resetn = 1'b1;

        // add r5 then dependent add r6 <- r5 via slot 0
        nxt(); issue(5'd5);
        nxt(); rd1(5'd5); fwd(0, 1, 1, 5'd5, 32'h0000_1234); issue(5'd6);
        #2;
        chk("b2b_fwd_value", rs1_value, 32'h0000_1234);
        chk("b2b_fwd_stall", {31'd0, stall}, 32'd0);
        nxt(); wb(5'd5);
        nxt(); wb(5'd6); rd1(5'd5); fwd(0, 1, 1, 5'd5, 32'hBAD0_BAD0);
        #2;
        chk("stale_fwd_ignored", rs1_value, RF1);

        // load-use: one stall cycle, then slot 1 supplies the data
        nxt(); issue(5'd4);
        nxt(); rd1(5'd4); fwd(0, 1, 0, 5'd4, 32'h0);
        #2;
        chk("load_use_stall", {31'd0, stall}, 32'd1);
        nxt(); rd1(5'd4); fwd(1, 1, 1, 5'd4, 32'h0000_DEAD); issue(5'd7);
        #2;
        chk("load_use_value", rs1_value, 32'h0000_DEAD);
        chk("load_use_release", {31'd0, stall}, 32'd0);
        nxt(); wb(5'd4);
        nxt(); wb(5'd7);

        // younger slot not ready shadows an older ready one
        nxt(); issue(5'd3);
        nxt(); rs2_addr = 5'd3; rs2_need = 1'b1;
        fwd(0, 1, 0, 5'd3, 32'h0); fwd(2, 1, 1, 5'd3, 32'h5555_5555);
        #2;
        chk("shadow_stall", {31'd0, stall}, 32'd1);
        chk("shadow_no_old_data", {31'd0, rs2_value != 32'h5555_5555}, 32'd1);
        nxt(); wb(5'd3);

        // counter saturation on r9
        nxt(); issue(5'd9);
        nxt(); issue(5'd9);
        nxt(); issue(5'd9);
        nxt(); issue_we = 1'b1; issue_dest = 5'd9;
        #2;
        chk("full_stall", {31'd0, stall}, 32'd1);
        nxt(); issue_we = 1'b1; issue_dest = 5'd9; wb(5'd9);
        #2;
        chk("full_stall_until_drop", {31'd0, stall}, 32'd1);
        nxt(); issue_we = 1'b1; issue_dest = 5'd9;
        #2;
        chk("full_cleared", {31'd0, stall}, 32'd0);
        nxt(); wb(5'd9);
        nxt(); wb(5'd9);
        nxt(); rd1(5'd9);
        #2;
        chk("r9_drained", {31'd0, stall}, 32'd0);

        // same-cycle issue and wb on r8, then flush
        nxt(); issue(5'd8);
        nxt(); issue(5'd8); wb(5'd8);
        nxt(); rd1(5'd8);
        #2;
        chk("r8_still_pending", {31'd0, stall}, 32'd1);
        nxt(); wb(5'd8);
        nxt(); rd1(5'd8);
        #2;
        chk("r8_was_one", {31'd0, stall}, 32'd0);
        nxt(); issue(5'd8);
        nxt(); flush = 1'b1; issue(5'd8); wb(5'd8);
        nxt(); rd1(5'd8); fwd(0, 1, 1, 5'd8, 32'h0BAD_0BAD);
        #2;
        chk("flush_rf_value", rs1_value, RF1);
        chk("flush_no_stall", {31'd0, stall}, 32'd0);

        // async reset in the middle of a stall
        nxt(); issue(5'd2);
        nxt(); issue(5'd2);
        guard = 0;
        nxt(); rd1(5'd2);
        while (msc < 17 && guard < 100) begin
            nxt(); rd1(5'd2);
            guard++;
        end
        chk("stall_budget", {31'd0, guard < 100}, 32'd1);
        #2;
        chk("stall_cnt_17", stall_cnt, 32'd17);
        chk("stall_held", {31'd0, stall}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        chk("midrst_rs1", rs1_value, RF1);
        nxt(); resetn = 1'b1; rd1(5'd2);
        #2;
        chk("post_rst_idle", {31'd0, stall}, 32'd0);
        nxt();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register scoreboard and operand-resolve unit for the decode stage of the LoongArch pipeline. It tracks outstanding register writes with per-register pending counters and selects operands from N forwarding sources or the regfile. It asserts a decode stall for unresolved RAW hazards (loads, multi-cycle mul/div) and for pending-counter overflow. It replaces fixed EX/MEM/WB compare chains, so adding pipeline stages or variable-latency producers needs no decode rewrite.

## Interface
- NREG, 32: architectural registers; r0 is never tracked.
- AW, 5: register address width, equal to log2(NREG).
- DW, 32: data width.
- NFWD, 3: number of forwarding sources; index 0 is the youngest (EX), index NFWD-1 the oldest (WB).
- CNTW, 2: pending-counter width; max outstanding writes per register is 2^CNTW-1.
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- rs1_addr, rs2_addr  in  AW each  source register addresses.
- rs1_need, rs2_need  in  1 each  source is actually read.
- rf_rdata1, rf_rdata2  in  DW each  regfile read data.
- fwd_valid  in  NFWD  source holds a register-writing instruction.
- fwd_ready  in  NFWD  source result is final this cycle (0 for a load in EX or a busy div).
- fwd_dest  in  NFWD*AW  destination per source.
- fwd_data  in  NFWD*DW  result per source.
- issue_fire  in  1  decode→EX handshake completes (id_ex_valid & ex_allowin).
- issue_we, issue_dest  in  1, AW  issuing instruction writes issue_dest.
- wb_we, wb_dest  in  1, AW  register write retiring this cycle.
- flush  in  1  kill all in-flight producers.
- rs1_value, rs2_value  out  DW each  resolved operands.
- stall  out  1  decode must not fire (id_ready_go = ~stall).
- stall_cnt  out  32  saturating count of stalled cycles.

## Operation
- cnt[r], for r=1..NREG-1, is a pending counter. cnt[0] is hard-wired to 0.
- Per source (src = rs1 or rs2), resolution is combinational:
  - need=0 or addr=0: value = rf_rdata; no hazard.
  - cnt[addr]==0: value = rf_rdata; all fwd inputs for addr are ignored as stale.
  - cnt[addr]!=0: find the lowest index i with fwd_valid[i] && fwd_dest[i]==addr.
    - Match with fwd_ready[i]=1: value = fwd_data[i]; no hazard.
    - Match with fwd_ready[i]=0: hazard. An older ready match must not be used.
    - No match: hazard, because the producer is in a stage not exposed.
- stall = hazard_rs1 | hazard_rs2 | (issue_we && issue_dest!=0 && cnt[issue_dest]==max).
- Counter update at posedge, with priority top to bottom:
  - flush: all cnt cleared to 0. issue and wb in the same cycle are ignored.
  - inc = issue_fire && issue_we && issue_dest!=0.
  - dec = wb_we && wb_dest!=0 && cnt[wb_dest]!=0.
  - Same register with inc and dec both true: counter is unchanged.
  - Otherwise: +1 or -1 on the respective register.
- issue_fire while stall=1 is a protocol violation. It is flagged by assertion, and the counter still updates.
- stall_cnt increments each cycle stall=1 and saturates at 0xFFFF_FFFF. It is not cleared by flush.

## Timing
- Operand resolve and stall are purely combinational from inputs and cnt, with zero latency.
- cnt, stall_cnt and all state are registers that update at posedge clk.
- resetn low clears cnt and stall_cnt asynchronously. Outputs then follow: stall=0, and rs*_value=rf_rdata*.
- Reset deasserted mid-operation: the first cycle runs with all counters at 0. Upstream must be flushed too.
- Issue at cycle t makes cnt visible at t+1. A dependent instruction decoded at t+1 sees cnt!=0 and must find its producer in fwd slot 0.
- Write retiring at cycle t: fwd slot NFWD-1 supplies data during t, and cnt drops at t+1, when the regfile already holds the value.

## Structure
- Shared package `sb_pkg`: AW, DW, NREG, CNTW, NFWD defaults and a CNT_MAX constant.
- Sub-module `sb_src_resolve`, instantiated twice: priority forward select plus the hazard flag for one source.
- Top level holds the counter array, the update logic and stall_cnt.

## Test plan
- Back-to-back add r5←… then add r6←r5: fwd slot 0 ready with 0x1234 → rs1_value=0x1234, stall=0.
- ld.w r4, then add r7←r4 immediately: slot 0 valid, ready=0 → stall=1 for exactly one cycle. Next cycle slot 1 ready with 0xDEAD → value 0xDEAD, stall=0.
- Older slot ready, younger not: slots 0 and 2 both dest r3, slot 0 ready=0 → stall=1, and slot 2 data is not used.
- Three issues to r9 with CNTW=2 and no writeback → cnt=3. A fourth issue_we to r9 asserts stall. One wb to r9 → cnt=2 and the stall clears.
- Issue and wb to r8 in the same cycle with cnt=1 → cnt stays 1. flush with cnt[8]=1 → cnt=0 next cycle, and reads of r8 take rf_rdata.
- resetn pulsed low mid-stall with cnt[2]=2 and stall_cnt=17 → immediately cnt=0, stall=0, stall_cnt=0.
